// File: rtl/axi4s_pkg.sv
// Shared definitions for the fixed-point AXI4-Stream blocks.
// Contains FSM state codes, a constant clog2 and a signed saturating clamp.
package axi4s_pkg;

  typedef enum logic [1:0] {
    STATE_INIT   = 2'd0,
    STATE_ACCUM  = 2'd1,
    STATE_OUTPUT = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Clamps a sign-extended value into the signed range of an out_w-bit word.
  // The caller keeps the low out_w bits; comparing against the input reveals clamping.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                   input int out_w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/axi4s_accumulator.sv
// Streaming group accumulator: sums up to ACC_LEN signed samples (or until tlast)
// and emits one saturated result per group with a clamp flag in tuser.
module axi4s_accumulator
  import axi4s_pkg::*;
#(
  parameter int DATA_BYTES = 2,
  parameter int ACC_LEN    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tvalid_slave,
  input  logic [8*DATA_BYTES-1:0] tdata_slave,
  input  logic                    tlast_slave,
  output logic                    tready_slave,
  output logic                    tvalid_master,
  output logic [8*DATA_BYTES-1:0] tdata_master,
  output logic                    tuser_master,
  input  logic                    tready_master
);

  localparam int W     = 8 * DATA_BYTES;
  localparam int CNT_W = clog2(ACC_LEN);
  localparam int ACC_W = W + CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ACC_LEN - 1);

  state_t                  state;
  state_t                  state_next;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_next;
  logic                    tready_next;
  logic                    tvalid_next;
  logic                    tuser_next;
  logic [W-1:0]            tdata_next;
  logic signed [63:0]      sum_wide;
  logic signed [63:0]      sum_clamped;
  logic                    in_xfer;
  logic                    out_xfer;

  assign in_xfer     = tvalid_slave & tready_slave;
  assign out_xfer    = tvalid_master & tready_master;
  assign sum         = acc + {{(ACC_W - W){tdata_slave[W-1]}}, tdata_slave};
  assign sum_wide    = 64'(sum);
  assign sum_clamped = sat_clamp(sum_wide, W);

  // The closing sample never lands in acc; it goes straight through the clamp.
  always_comb begin
    state_next  = state;
    acc_next    = acc;
    count_next  = count;
    tready_next = tready_slave;
    tvalid_next = tvalid_master;
    tdata_next  = tdata_master;
    tuser_next  = tuser_master;
    case (state)
      STATE_INIT: begin
        tready_next = 1'b1;
        state_next  = STATE_ACCUM;
      end
      STATE_ACCUM: begin
        if (in_xfer) begin
          if ((count == LAST_COUNT) || tlast_slave) begin
            tdata_next  = sum_clamped[W-1:0];
            tuser_next  = (sum_clamped != sum_wide);
            tvalid_next = 1'b1;
            tready_next = 1'b0;
            state_next  = STATE_OUTPUT;
          end else begin
            acc_next   = sum;
            count_next = count + CNT_W'(1);
          end
        end
      end
      STATE_OUTPUT: begin
        if (out_xfer) begin
          tvalid_next = 1'b0;
          tuser_next  = 1'b0;
          acc_next    = '0;
          count_next  = '0;
          tready_next = 1'b1;
          state_next  = STATE_ACCUM;
        end
      end
      default: begin
        state_next  = STATE_INIT;
        tready_next = 1'b0;
        tvalid_next = 1'b0;
        tuser_next  = 1'b0;
        acc_next    = '0;
        count_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= STATE_INIT;
      acc           <= '0;
      count         <= '0;
      tready_slave  <= 1'b0;
      tvalid_master <= 1'b0;
      tdata_master  <= '0;
      tuser_master  <= 1'b0;
    end else begin
      state         <= state_next;
      acc           <= acc_next;
      count         <= count_next;
      tready_slave  <= tready_next;
      tvalid_master <= tvalid_next;
      tdata_master  <= tdata_next;
      tuser_master  <= tuser_next;
    end
  end

endmodule

// File: tb/tb_axi4s_accumulator.sv
// Self-checking bench for axi4s_accumulator: a group-sum model checks both a
// 4-sample and an 8-sample instance every cycle; directed vectors pin literal results.
module tb_axi4s_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        tvalid_s [2];
  logic [15:0] tdata_s  [2];
  logic        tlast_s  [2];
  logic        tready_s [2];
  logic        tvalid_m [2];
  logic [15:0] tdata_m  [2];
  logic        tuser_m  [2];
  logic        tready_m [2];

  int vectors     = 0;
  int miscompares = 0;

  // Model state: running group sum, samples in group, pending result.
  int          sum       [2];
  int          cnt       [2];
  logic        pend      [2];
  logic [15:0] pend_data [2];
  logic        pend_user [2];
  logic        rst_seen  [2];
  logic        settle    [2];
  int          outs      [2];
  logic [15:0] last_data [2];
  logic        last_user [2];

  always #5 clk = ~clk;

  axi4s_accumulator #(.DATA_BYTES(2), .ACC_LEN(4)) dut4 (
    .clk(clk), .reset(reset),
    .tvalid_slave(tvalid_s[0]), .tdata_slave(tdata_s[0]), .tlast_slave(tlast_s[0]),
    .tready_slave(tready_s[0]), .tvalid_master(tvalid_m[0]), .tdata_master(tdata_m[0]),
    .tuser_master(tuser_m[0]), .tready_master(tready_m[0])
  );

  axi4s_accumulator #(.DATA_BYTES(2), .ACC_LEN(8)) dut8 (
    .clk(clk), .reset(reset),
    .tvalid_slave(tvalid_s[1]), .tdata_slave(tdata_s[1]), .tlast_slave(tlast_s[1]),
    .tready_slave(tready_s[1]), .tvalid_master(tvalid_m[1]), .tdata_master(tdata_m[1]),
    .tuser_master(tuser_m[1]), .tready_master(tready_m[1])
  );

  function automatic int group_len(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  function automatic logic [16:0] clamp16(input int s);
    if (s > 32767) return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(s)};
  endfunction

  task automatic check_output(input string name, input int k,
                              input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s[dut%0d] at %0t: got 0x%0h, expected 0x%0h",
               name, k, $time, actual, expected);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      sum[k] = 0; cnt[k] = 0; pend[k] = 1'b0; pend_data[k] = '0; pend_user[k] = 1'b0;
      rst_seen[k] = 1'b1; settle[k] = 1'b1; outs[k] = 0; last_data[k] = '0; last_user[k] = 1'b0;
    end
  end

  // Model update on each rising edge, using values present just before it.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [16:0] c;
      rst_seen[k] = reset;
      if (reset) begin
        sum[k] = 0; cnt[k] = 0; pend[k] = 1'b0; pend_user[k] = 1'b0; settle[k] = 1'b1;
      end else begin
        if (tvalid_m[k] && tready_m[k]) begin
          outs[k]++;
          last_data[k] = tdata_m[k];
          last_user[k] = tuser_m[k];
          pend[k] = 1'b0;
        end
        if (tvalid_s[k] && tready_s[k]) begin
          sum[k] += int'($signed(tdata_s[k]));
          cnt[k]++;
          if (cnt[k] == group_len(k) || tlast_s[k]) begin
            check_output("accept_while_pending", k, pend[k], 0);
            c = clamp16(sum[k]);
            pend[k] = 1'b1; pend_data[k] = c[15:0]; pend_user[k] = c[16];
            sum[k] = 0; cnt[k] = 0;
          end
        end
        settle[k] = 1'b0;
      end
    end
  end

  // Compare process: every cycle, on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_seen[k]) begin
        check_output("rst_tvalid_master", k, tvalid_m[k], 0);
        check_output("rst_tdata_master", k, tdata_m[k], 0);
        check_output("rst_tuser_master", k, tuser_m[k], 0);
        check_output("rst_tready_slave", k, tready_s[k], 0);
      end else begin
        check_output("tvalid_master", k, tvalid_m[k], pend[k]);
        if (pend[k]) begin
          check_output("tdata_master", k, tdata_m[k], pend_data[k]);
          check_output("tuser_master", k, tuser_m[k], pend_user[k]);
        end else begin
          check_output("tuser_idle", k, tuser_m[k], 0);
        end
        check_output("tready_slave", k, tready_s[k], settle[k] ? 1'b0 : !pend[k]);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the sample is taken.
  task automatic apply_stimulus(input int k, input logic [15:0] d, input logic last);
    int waited;
    waited = 0;
    tvalid_s[k] = 1'b1; tdata_s[k] = d; tlast_s[k] = last;
    while (!tready_s[k] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!tready_s[k]) begin
      vectors++; miscompares++;
      $display("[TB] FAIL accept_timeout[dut%0d]: tready_slave stayed 0 for %0d cycles", k, waited);
    end else begin
      @(negedge clk);
    end
    tvalid_s[k] = 1'b0; tlast_s[k] = 1'b0;
  endtask

  task automatic wait_out(input int k, input int target, input string name);
    int n;
    n = 0;
    while (outs[k] < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output(name, k, outs[k], target);
  endtask

  task automatic send4(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    apply_stimulus(k, a, 1'b0);
    apply_stimulus(k, b, 1'b0);
    apply_stimulus(k, c, 1'b0);
    apply_stimulus(k, d, 1'b0);
  endtask

  initial begin
    int          base;
    int          s;
    logic [15:0] v;
    logic [16:0] e;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tvalid_s[k] = 1'b0; tdata_s[k] = '0; tlast_s[k] = 1'b0; tready_m[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    check_output("reset_tready_slave", 0, tready_s[0], 0);
    check_output("reset_tvalid_master", 0, tvalid_m[0], 0);
    reset = 1'b0;

    $display("[TB] basic sum");
    base = outs[0];
    send4(0, 16'd1, 16'd2, 16'd3, 16'd4);
    check_output("t1_valid_after_last", 0, tvalid_m[0], 1);
    check_output("t1_ready_low", 0, tready_s[0], 0);
    wait_out(0, base + 1, "t1_out_count");
    check_output("t1_data", 0, last_data[0], 16'h000A);
    check_output("t1_user", 0, last_user[0], 0);
    check_output("t1_ready_back", 0, tready_s[0], 1);

    $display("[TB] saturation");
    base = outs[0];
    send4(0, 16'h7000, 16'h7000, 16'h7000, 16'h7000);
    wait_out(0, base + 1, "t2p_out_count");
    check_output("t2p_data", 0, last_data[0], 16'h7FFF);
    check_output("t2p_user", 0, last_user[0], 1);
    send4(0, 16'h9000, 16'h9000, 16'h9000, 16'h9000);
    wait_out(0, base + 2, "t2n_out_count");
    check_output("t2n_data", 0, last_data[0], 16'h8000);
    check_output("t2n_user", 0, last_user[0], 1);
    send4(0, 16'hFFFD, 16'h0001, 16'hFFFF, 16'h0000);
    wait_out(0, base + 3, "t2m_out_count");
    check_output("t2m_data", 0, last_data[0], 16'hFFFD);
    check_output("t2m_user", 0, last_user[0], 0);

    $display("[TB] early tlast");
    base = outs[0];
    apply_stimulus(0, 16'h0005, 1'b0);
    apply_stimulus(0, 16'h0006, 1'b1);
    wait_out(0, base + 1, "t3_out_count");
    check_output("t3_data", 0, last_data[0], 16'h000B);
    send4(0, 16'd1, 16'd1, 16'd1, 16'd1);
    wait_out(0, base + 2, "t3b_out_count");
    check_output("t3b_data", 0, last_data[0], 16'h0004);
    apply_stimulus(0, 16'h1234, 1'b1);
    wait_out(0, base + 3, "t3c_out_count");
    check_output("t3c_single", 0, last_data[0], 16'h1234);
    apply_stimulus(0, 16'd1, 1'b0);
    apply_stimulus(0, 16'd1, 1'b0);
    apply_stimulus(0, 16'd1, 1'b0);
    apply_stimulus(0, 16'd1, 1'b1);
    wait_out(0, base + 4, "t3d_out_count");
    repeat (4) @(negedge clk);
    check_output("t3d_no_double", 0, outs[0], base + 4);
    check_output("t3d_data", 0, last_data[0], 16'h0004);
    apply_stimulus(0, 16'd2, 1'b0);
    tlast_s[0] = 1'b1;
    repeat (3) @(negedge clk);
    tlast_s[0] = 1'b0;
    apply_stimulus(0, 16'd3, 1'b0);
    apply_stimulus(0, 16'd4, 1'b0);
    apply_stimulus(0, 16'd5, 1'b0);
    wait_out(0, base + 5, "t3e_out_count");
    check_output("t3e_idle_tlast", 0, last_data[0], 16'h000E);

    $display("[TB] backpressure");
    base = outs[0];
    tready_m[0] = 1'b0;
    send4(0, 16'd1, 16'd2, 16'd3, 16'd4);
    tvalid_s[0] = 1'b1; tdata_s[0] = 16'h0100;
    repeat (5) @(negedge clk);
    check_output("t4_held_valid", 0, tvalid_m[0], 1);
    check_output("t4_held_data", 0, tdata_m[0], 16'h000A);
    check_output("t4_no_out", 0, outs[0], base);
    tvalid_s[0] = 1'b0;
    tready_m[0] = 1'b1;
    wait_out(0, base + 1, "t4_out_count");
    check_output("t4_data", 0, last_data[0], 16'h000A);
    repeat (3) @(negedge clk);
    check_output("t4_single_out", 0, outs[0], base + 1);
    send4(0, 16'd1, 16'd1, 16'd1, 16'd1);
    wait_out(0, base + 2, "t4b_out_count");
    check_output("t4b_data", 0, last_data[0], 16'h0004);

    $display("[TB] reset mid-group");
    base = outs[0];
    apply_stimulus(0, 16'd7, 1'b0);
    apply_stimulus(0, 16'd7, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("t5_ready_in_reset", 0, tready_s[0], 0);
    check_output("t5_valid_in_reset", 0, tvalid_m[0], 0);
    @(negedge clk);
    check_output("t5_ready_after", 0, tready_s[0], 1);
    base = outs[0];
    send4(0, 16'd1, 16'd1, 16'd1, 16'd1);
    wait_out(0, base + 1, "t5_out_count");
    check_output("t5_data", 0, last_data[0], 16'h0004);

    $display("[TB] random gaps, 8-sample groups");
    base = outs[1];
    for (int g = 0; g < 1000; g++) begin
      s = 0;
      for (int i = 0; i < 8; i++) begin
        if (g % 2 == 0) v = 16'($urandom_range(0, 4095)) - 16'd2048;
        else            v = 16'($urandom);
        s += int'($signed(v));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        apply_stimulus(1, v, 1'b0);
      end
      e = clamp16(s);
      wait_out(1, base + g + 1, "t6_out_count");
      check_output("t6_data", 1, last_data[1], e[15:0]);
      check_output("t6_user", 1, last_user[1], e[16]);
    end
    repeat (3) @(negedge clk);
    check_output("t6_total_groups", 1, outs[1], base + 1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
